// File: rtl/vga_pixel_out.sv
// vga_pixel_out: VGA timing generator that pulls RGB222 words from upstream and drives the pins
module vga_pixel_out #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int PWIDTH    = 6
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [PWIDTH-1:0] PixelIn,
    input  logic              PixelEmpty,
    output logic              PixelRead,
    input  logic              UnderflowClr,
    output logic [1:0]        Red,
    output logic [1:0]        Green,
    output logic [1:0]        Blue,
    output logic              HSync,
    output logic              VSync,
    output logic              Active,
    output logic              FrameStart,
    output logic              Underflow
);
    localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(HTOTAL);
    localparam int VW = $clog2(VTOTAL);
    localparam logic [HW-1:0] H_VIS = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] H_MAX = HW'(HTOTAL - 1);
    localparam logic [VW-1:0] V_VIS = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] V_MAX = VW'(VTOTAL - 1);
    localparam logic HP = (HSYNC_POL != 0);
    localparam logic VP = (VSYNC_POL != 0);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic vis1, miss1, hs1, vs1, f1;
    logic vis2_q, miss2_q, hs2_q, vs2_q, f2_q, rd2_q;
    logic [1:0] red_q, green_q, blue_q;
    logic act_q, fs_q, hsync_q, vsync_q, uf_q, uf_d;

    // Stage 1: decode the current raster position; reads are blocked while reset is held
    assign vis1      = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    assign miss1     = vis1 && PixelEmpty;
    assign hs1       = (hcnt_q >= H_SS) && (hcnt_q <= H_SE);
    assign vs1       = (vcnt_q >= V_SS) && (vcnt_q <= V_SE);
    assign f1        = (hcnt_q == '0) && (vcnt_q == '0);
    assign PixelRead = vis1 && !PixelEmpty && !Reset;

    assign Red        = red_q;
    assign Green      = green_q;
    assign Blue       = blue_q;
    assign HSync      = hsync_q;
    assign VSync      = vsync_q;
    assign Active     = act_q;
    assign FrameStart = fs_q;
    assign Underflow  = uf_q;

    // Raster counter advance and sticky underflow next state (a new miss beats a clear)
    always_comb begin
        hcnt_d = (hcnt_q == H_MAX) ? '0 : hcnt_q + HW'(1);
        vcnt_d = (hcnt_q != H_MAX) ? vcnt_q : (vcnt_q == V_MAX) ? '0 : vcnt_q + VW'(1);
        uf_d   = miss2_q | (uf_q & ~UnderflowClr);
    end

    // Raster position counters
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Stage 2: hold timing flags while the requested word arrives from upstream
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vis2_q  <= 1'b0;
            miss2_q <= 1'b0;
            hs2_q   <= 1'b0;
            vs2_q   <= 1'b0;
            f2_q    <= 1'b0;
            rd2_q   <= 1'b0;
        end else begin
            vis2_q  <= vis1;
            miss2_q <= miss1;
            hs2_q   <= hs1;
            vs2_q   <= vs1;
            f2_q    <= f1;
            rd2_q   <= PixelRead;
        end
    end

    // Output register: pixel, sync and flags leave together, black when no word was read
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            red_q   <= 2'b0;
            green_q <= 2'b0;
            blue_q  <= 2'b0;
            act_q   <= 1'b0;
            fs_q    <= 1'b0;
            hsync_q <= ~HP;
            vsync_q <= ~VP;
            uf_q    <= 1'b0;
        end else begin
            red_q   <= rd2_q ? PixelIn[5:4] : 2'b0;
            green_q <= rd2_q ? PixelIn[3:2] : 2'b0;
            blue_q  <= rd2_q ? PixelIn[1:0] : 2'b0;
            act_q   <= vis2_q;
            fs_q    <= f2_q;
            hsync_q <= hs2_q ? HP : ~HP;
            vsync_q <= vs2_q ? VP : ~VP;
            uf_q    <= uf_d;
        end
    end
endmodule
